// File: rtl/snn_fp_pkg.sv
// Shared fp32 field constants, the threshold unit's FSM states and an fp32 NaN helper
// for the SNN accelerator datapath.
package snn_fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;

  localparam logic [7:0]  EXP_ALL_ONES      = 8'hFF;
  localparam logic [31:0] DEFAULT_THRESHOLD = 32'h41F00000;

  // Refractory counters hold 0..15 timesteps.
  localparam int REFR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    EMIT
  } state_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (x[MANT_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp32_ge.sv
// Combinational fp32 a >= b: NaN never compares true, +0 equals -0, and denormals
// are ordered by their raw bits.
module fp32_ge
  import snn_fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ge
);

  logic [30:0] a_mag;
  logic [30:0] b_mag;

  assign a_mag = a[EXP_MSB:0];
  assign b_mag = b[EXP_MSB:0];

  // NOTE: every path of an always_comb must assign its outputs, otherwise a latch is inferred.
  always_comb begin
    ge = 1'b0;
    if (is_nan(a) || is_nan(b)) begin
      ge = 1'b0;
    end else if (a_mag == '0 && b_mag == '0) begin
      ge = 1'b1;
    end else if (a[SIGN_BIT] != b[SIGN_BIT]) begin
      ge = !a[SIGN_BIT];
    end else if (!a[SIGN_BIT]) begin
      ge = (a_mag >= b_mag);
    end else begin
      ge = (a_mag <= b_mag);
    end
  end

endmodule

// File: rtl/spike_threshold_unit.sv
// LIF threshold stage: compares a decayed fp32 potential against the firing threshold,
// emits spike/post-fire potential and maintains per-neuron refractory counters.
module spike_threshold_unit
  import snn_fp_pkg::*;
#(
  parameter int          NUM_NEURONS     = 32,
  parameter int          ADDR_W          = 5,
  parameter int          REFRACTORY      = 2,
  parameter logic [31:0] THRESHOLD       = DEFAULT_THRESHOLD,
  parameter logic [31:0] RESET_POTENTIAL = 32'h00000000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              timestep_tick,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_potential,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential,
  output logic              out_spike,
  output logic [15:0]       spike_count
);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   lat_addr;
  logic [31:0]         lat_potential;
  logic [REFR_W-1:0]   refr_cnt [NUM_NEURONS];
  logic                above_threshold;
  logic                refractory;
  logic                fire;

  fp32_ge u_ge (
    .a  (lat_potential),
    .b  (THRESHOLD),
    .ge (above_threshold)
  );

  assign refractory = (refr_cnt[lat_addr] != '0);
  assign fire       = !refractory && above_threshold;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = COMPARE;
      end
      COMPARE: state_next = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      lat_addr      <= '0;
      lat_potential <= '0;
    end else if (state == IDLE && in_valid) begin
      lat_addr      <= in_addr;
      lat_potential <= in_potential;
    end
  end

  // NOTE: the refractory array is flops, not RAM, so it is reset; a pending refractory
  // period must not survive a reset.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) refr_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        // A fire-load beats a same-cycle tick on the same neuron.
        if (state == COMPARE && fire && lat_addr == ADDR_W'(i)) begin
          refr_cnt[i] <= REFR_W'(REFRACTORY);
        end else if (timestep_tick && refr_cnt[i] != '0) begin
          refr_cnt[i] <= refr_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out_addr      <= '0;
      out_potential <= '0;
      out_spike     <= 1'b0;
      spike_count   <= '0;
    end else if (state == COMPARE) begin
      out_addr      <= lat_addr;
      out_spike     <= fire;
      out_potential <= (fire || refractory) ? RESET_POTENTIAL : lat_potential;
      if (fire && spike_count != 16'hFFFF) spike_count <= spike_count + 1'b1;
    end
  end

endmodule
